matrix_feeder: RTL and testbench
================================

MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 SHALL have parameter N, default 3: systolic array dimension, giving N rows of A and N columns of B.
REQ-002 SHALL have parameter DRAIN, default 8: idle cycles after the last operand, allowing the array pipeline to settle.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1 bit: operand-store write strobe.
REQ-006 SHALL have port wr_sel, input, 1 bit: matrix select, 0 = A, 1 = B.
REQ-007 SHALL have ports wr_row and wr_col, input, $clog2(N) bits each: element indices.
REQ-008 SHALL have port wr_data, input, 8 bits: minifloat element (sign, 3-bit exponent, 4-bit fraction); 8'h00 means zero.
REQ-009 SHALL have port start, input, 1 bit: begin a feed sequence.
REQ-010 SHALL have port a_out, output, 8*N bits: lane i, bits [8i+7:8i], drives the a input of array row i.
REQ-011 SHALL have port b_out, output, 8*N bits: lane j drives the b input of array column j.
REQ-012 SHALL have port feed_valid, output, 1 bit: high while in FEED.
REQ-013 SHALL have port busy, output, 1 bit: high in FEED or DRAIN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL store A and B as two N x N arrays of 8-bit registers.
REQ-016 SHALL write wr_data to the selected matrix at the selected element on any edge where wr_en=1 and state=IDLE.
REQ-017 SHALL ignore a write whose wr_row or wr_col is >= N.
REQ-018 SHALL ignore writes in any state other than IDLE.
REQ-019 SHALL use states IDLE, FEED, DRAIN and DONE.
REQ-020 SHALL move IDLE -> FEED on an edge with start=1; start is ignored in all other states.
REQ-021 SHALL, when start and wr_en are both high in IDLE, honour start and discard the write.
REQ-022 SHALL remain in FEED for exactly 2N-1 cycles, with feed step t = 0..2N-2.
REQ-023 SHALL then remain in DRAIN for exactly DRAIN cycles, then spend 1 cycle in DONE, then return to IDLE.
REQ-024 SHALL register all outputs, so the values for step t appear in the t-th cycle of FEED.
REQ-025 SHALL, at FEED step t, drive a_out lane i with A[i][t-i] when 0 <= t-i < N, else 8'h00.
REQ-026 SHALL, at FEED step t, drive b_out lane j with B[t-j][j] when 0 <= t-j < N, else 8'h00.
REQ-027 SHALL drive every a_out and b_out lane to 8'h00 in IDLE, DRAIN and DONE.
REQ-028 SHALL set feed_valid=1 only in FEED, busy=1 only in FEED or DRAIN, and done=1 only in DONE.
REQ-029 SHALL use start-to-first-operand latency 1: start sampled at edge E puts step 0 on the outputs after E.
REQ-030 SHALL leave stored operands unchanged after a run, so a repeat start replays identical streams.
REQ-031 SHALL treat element values as opaque; no arithmetic is performed on them.

Reset
REQ-032 SHALL, on an edge with rst=1 in any state (including mid-FEED or mid-DRAIN), go to IDLE.
REQ-033 SHALL, on that same reset edge, clear every A and B element to 8'h00.
REQ-034 SHALL, on that same reset edge, drive all lanes to 8'h00 and set feed_valid=0, busy=0 and done=0.
REQ-035 SHALL give rst priority over start and wr_en on the same edge.

Verification
REQ-036 Reset test: assert rst for 2 cycles -> all lanes 8'h00, feed_valid/busy/done=0; start with no writes -> all-zero streams.
REQ-037 Skew test (N=3): load A[i][k]=8'h10*(i+1)+k and B[k][j]=8'h40+8'h10*k+j, then start at edge E -> after E: a_out=(8'h10,0,0), b_out=(8'h40,0,0). After E+1: a_out=(8'h11,8'h20,0), b_out=(8'h50,8'h41,0). After E+4: a_out=(0,0,8'h32), b_out=(0,0,8'h62).
REQ-038 Timing test (N=3, DRAIN=8): start at E -> feed_valid high after E..E+4, busy high after E..E+12, done high only after E+13, IDLE after E+14.
REQ-039 Lockout test: during FEED pulse start and write A[0][0]=8'h7F -> no restart; the following run still emits 8'h10 at step 0.
REQ-040 Mid-run reset test: assert rst at FEED step 2 -> next cycle all lanes 0 and busy=0; a new start yields all-zero streams.
REQ-041 Write-rule test: wr_row=3 with wr_data=8'hAA, and start+wr_en on the same edge -> no element changes; the run proceeds normally.

Source files
------------

// File: rtl/matrix_feeder.sv
// Operand feeder for an N x N systolic array: holds matrices A and B and streams
// them out row/column-skewed, one diagonal wavefront per cycle, then drains.
module matrix_feeder #(
    parameter int N     = 3,
    parameter int DRAIN = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(N)-1:0]   wr_row,
    input  logic [$clog2(N)-1:0]   wr_col,
    input  logic [7:0]             wr_data,
    input  logic                   start,
    output logic [8*N-1:0]         a_out,
    output logic [8*N-1:0]         b_out,
    output logic                   feed_valid,
    output logic                   busy,
    output logic                   done
);
    localparam int IW   = $clog2(N);
    localparam int CMAX = (2*N-1 > DRAIN) ? 2*N-1 : DRAIN;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [IW:0]   N_L        = (IW+1)'(N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2*N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      a_mem_q [N][N];
    logic [7:0]      a_mem_d [N][N];
    logic [7:0]      b_mem_q [N][N];
    logic [7:0]      b_mem_d [N][N];
    logic [8*N-1:0]  a_out_q, a_out_d;
    logic [8*N-1:0]  b_out_q, b_out_d;
    logic            feed_valid_q, feed_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    int              k_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_mem_d = a_mem_q;
        b_mem_d = b_mem_q;
        k_idx   = 0;
        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous write
                if (start) begin
                    state_d = ST_FEED;
                    cnt_d   = '0;
                end else if (wr_en && ({1'b0, wr_row} < N_L) && ({1'b0, wr_col} < N_L)) begin
                    if (wr_sel) b_mem_d[wr_row][wr_col] = wr_data;
                    else        a_mem_d[wr_row][wr_col] = wr_data;
                end
            end
            ST_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    cnt_d   = '0;
                    state_d = (DRAIN > 0) ? ST_DRAIN : ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are computed for the upcoming step so they are registered in step.
        a_out_d = '0;
        b_out_d = '0;
        if (state_d == ST_FEED) begin
            for (int i = 0; i < N; i++) begin
                k_idx = int'(cnt_d) - i;
                if (k_idx >= 0 && k_idx < N) begin
                    a_out_d[8*i +: 8] = a_mem_q[IW'(i)][IW'(k_idx)];
                    b_out_d[8*i +: 8] = b_mem_q[IW'(k_idx)][IW'(i)];
                end
            end
        end
        feed_valid_d = (state_d == ST_FEED);
        busy_d       = (state_d == ST_FEED) || (state_d == ST_DRAIN);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_mem_q      <= '{default: '0};
            b_mem_q      <= '{default: '0};
            a_out_q      <= '0;
            b_out_q      <= '0;
            feed_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_mem_q      <= a_mem_d;
            b_mem_q      <= b_mem_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            feed_valid_q <= feed_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign a_out      = a_out_q;
    assign b_out      = b_out_q;
    assign feed_valid = feed_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_matrix_feeder.sv
// Self-checking bench for matrix_feeder: directed scenarios plus randomized loads,
// compared against a matrix-level model of the skewed operand streams.
module tb_matrix_feeder;
    localparam int N     = 3;
    localparam int DRAIN = 8;
    localparam int RUN   = 2*N - 1 + DRAIN + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic             wr_sel = 1'b0;
    logic [1:0]       wr_row = '0;
    logic [1:0]       wr_col = '0;
    logic [7:0]       wr_data = '0;
    logic             start = 1'b0;
    logic [8*N-1:0]   a_out, b_out;
    logic             feed_valid, busy, done;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ma [N][N];
    logic [7:0]  mb [N][N];
    logic [23:0] cap_a [RUN];
    logic [23:0] cap_b [RUN];
    logic [2:0]  cap_c [RUN];

    matrix_feeder #(.N(N), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
        .a_out(a_out), .b_out(b_out), .feed_valid(feed_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: lane i of A at step t carries A[i][t-i]; lane j of B carries B[t-j][j].
    function automatic logic [23:0] exp_a(int c);
        logic [23:0] r = '0;
        for (int i = 0; i < N; i++)
            if (c < 2*N-1 && c-i >= 0 && c-i < N) r[8*i +: 8] = ma[i][c-i];
        return r;
    endfunction

    function automatic logic [23:0] exp_b(int c);
        logic [23:0] r = '0;
        for (int j = 0; j < N; j++)
            if (c < 2*N-1 && c-j >= 0 && c-j < N) r[8*j +: 8] = mb[c-j][j];
        return r;
    endfunction

    // {feed_valid, busy, done} for the c-th cycle after the start edge
    function automatic logic [2:0] exp_ctrl(int c);
        return {c < 2*N-1, c < 2*N-1+DRAIN, c == 2*N-1+DRAIN};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 8'h00;
                mb[i][j] = 8'h00;
            end
    endtask

    task automatic wr(input bit sel, input int row, input int col, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(row); wr_col = 2'(col); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (row < N && col < N) begin
            if (sel) mb[row][col] = d;
            else     ma[row][col] = d;
        end
    endtask

    task automatic load_skew();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                wr(1'b0, i, k, 8'(8'h10*(i+1) + k));
                wr(1'b1, i, k, 8'(8'h40 + 8'h10*i + k));
            end
    endtask

    // Pulse start and record RUN cycles of outputs. inj >= 0 pulses start plus a
    // write of A[0][0]=7F for the edge after capture index inj.
    task automatic capture(input int inj, input bit wr_with_start);
        start = 1'b1;
        if (wr_with_start) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'hAA;
        end
        tick();
        start = 1'b0; wr_en = 1'b0;
        cap_a[0] = a_out; cap_b[0] = b_out; cap_c[0] = {feed_valid, busy, done};
        for (int c = 1; c < RUN; c++) begin
            if (c - 1 == inj) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
                wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h7F;
            end
            tick();
            start = 1'b0; wr_en = 1'b0;
            cap_a[c] = a_out; cap_b[c] = b_out; cap_c[c] = {feed_valid, busy, done};
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
        tick(); tick();
        rst = 1'b0; start = 1'b0; wr_en = 1'b0;
        model_clear();
        checks++;
        if ({a_out, b_out, feed_valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_out got a=%h b=%h ctrl=%b want all 0", a_out, b_out, {feed_valid, busy, done});
        end
        tick();
        checks++;
        if ({feed_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_prio ctrl=%b want 000", {feed_valid, busy, done});
        end
        capture(-1, 1'b0);
        for (int c = 0; c < RUN; c++) begin
            checks++;
            if (cap_a[c] !== exp_a(c) || cap_b[c] !== exp_b(c) || cap_c[c] !== exp_ctrl(c)) begin
                errors++;
                $display("FAIL reset_run c=%0d got a=%h b=%h ctrl=%b want a=%h b=%h ctrl=%b",
                         c, cap_a[c], cap_b[c], cap_c[c], exp_a(c), exp_b(c), exp_ctrl(c));
            end
        end
    endtask

    task automatic test_skew();
        load_skew();
        capture(-1, 1'b0);
        for (int c = 0; c < RUN; c++) begin
            checks++;
            if (cap_a[c] !== exp_a(c) || cap_b[c] !== exp_b(c) || cap_c[c] !== exp_ctrl(c)) begin
                errors++;
                $display("FAIL skew_run c=%0d got a=%h b=%h ctrl=%b want a=%h b=%h ctrl=%b",
                         c, cap_a[c], cap_b[c], cap_c[c], exp_a(c), exp_b(c), exp_ctrl(c));
            end
        end
        checks++;
        if (cap_a[0] !== 24'h000010 || cap_b[0] !== 24'h000040) begin
            errors++;
            $display("FAIL skew_step0 got a=%h b=%h want a=000010 b=000040", cap_a[0], cap_b[0]);
        end
        checks++;
        if (cap_a[1] !== 24'h002011 || cap_b[1] !== 24'h004150) begin
            errors++;
            $display("FAIL skew_step1 got a=%h b=%h want a=002011 b=004150", cap_a[1], cap_b[1]);
        end
        checks++;
        if (cap_a[4] !== 24'h320000 || cap_b[4] !== 24'h620000) begin
            errors++;
            $display("FAIL skew_step4 got a=%h b=%h want a=320000 b=620000", cap_a[4], cap_b[4]);
        end
        checks++;
        if (cap_c[4] !== 3'b110 || cap_c[5] !== 3'b010 || cap_c[12] !== 3'b010 ||
            cap_c[13] !== 3'b001 || cap_c[14] !== 3'b000) begin
            errors++;
            $display("FAIL timing got c4=%b c5=%b c12=%b c13=%b c14=%b want 110 010 010 001 000",
                     cap_c[4], cap_c[5], cap_c[12], cap_c[13], cap_c[14]);
        end
    endtask

    task automatic test_lockout();
        capture(1, 1'b0);
        for (int c = 0; c < RUN; c++) begin
            checks++;
            if (cap_a[c] !== exp_a(c) || cap_b[c] !== exp_b(c) || cap_c[c] !== exp_ctrl(c)) begin
                errors++;
                $display("FAIL lockout_run c=%0d got a=%h b=%h ctrl=%b want a=%h b=%h ctrl=%b",
                         c, cap_a[c], cap_b[c], cap_c[c], exp_a(c), exp_b(c), exp_ctrl(c));
            end
        end
        capture(-1, 1'b0);
        checks++;
        if (cap_a[0][7:0] !== 8'h10) begin
            errors++;
            $display("FAIL lockout_a00 got %h want 10", cap_a[0][7:0]);
        end
    endtask

    task automatic test_write_rule();
        wr(1'b0, 3, 0, 8'hAA);
        wr(1'b1, 0, 3, 8'hAA);
        wr(1'b0, 3, 3, 8'hAA);
        capture(-1, 1'b1);
        for (int c = 0; c < RUN; c++) begin
            checks++;
            if (cap_a[c] !== exp_a(c) || cap_b[c] !== exp_b(c) || cap_c[c] !== exp_ctrl(c)) begin
                errors++;
                $display("FAIL wrule_run c=%0d got a=%h b=%h ctrl=%b want a=%h b=%h ctrl=%b",
                         c, cap_a[c], cap_b[c], cap_c[c], exp_a(c), exp_b(c), exp_ctrl(c));
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 24; w++)
                wr(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                   8'($urandom));
            // second pass replays the same stored operands
            for (int rep = 0; rep < 2; rep++) begin
                capture(-1, 1'b0);
                for (int c = 0; c < RUN; c++) begin
                    checks++;
                    if (cap_a[c] !== exp_a(c) || cap_b[c] !== exp_b(c) || cap_c[c] !== exp_ctrl(c)) begin
                        errors++;
                        $display("FAIL rand_run r=%0d rep=%0d c=%0d got a=%h b=%h ctrl=%b want a=%h b=%h ctrl=%b",
                                 r, rep, c, cap_a[c], cap_b[c], cap_c[c], exp_a(c), exp_b(c), exp_ctrl(c));
                    end
                end
            end
        end
    endtask

    task automatic test_midreset();
        load_skew();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (a_out !== exp_a(2) || feed_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_step2 got a=%h fv=%b want a=%h fv=1", a_out, feed_valid, exp_a(2));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        checks++;
        if ({a_out, b_out, feed_valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL midrst_out got a=%h b=%h ctrl=%b want all 0", a_out, b_out, {feed_valid, busy, done});
        end
        capture(-1, 1'b0);
        for (int c = 0; c < RUN; c++) begin
            checks++;
            if (cap_a[c] !== exp_a(c) || cap_b[c] !== exp_b(c) || cap_c[c] !== exp_ctrl(c)) begin
                errors++;
                $display("FAIL midrst_run c=%0d got a=%h b=%h ctrl=%b want a=%h b=%h ctrl=%b",
                         c, cap_a[c], cap_b[c], cap_c[c], exp_a(c), exp_b(c), exp_ctrl(c));
            end
        end
    endtask

    initial begin
        model_clear();
        tick();
        test_reset();
        test_skew();
        test_lockout();
        test_write_rule();
        test_random();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
